fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage floating-point multiplier (flush-to-zero) with global valid/ready stall.
// Rounding: define FP_MULT_PIPE_RNE_EN for round-to-nearest-even; otherwise truncate.
module fp_mult_pipe #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  parameter  int unsigned TAG_W = 4,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int unsigned M    = MAN_W + 1;
  localparam int unsigned PW   = 2 * M;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned RW   = MAN_W + 1;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

  typedef struct packed {
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic [EW-1:0]    e;
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic [EW-1:0]    e;
    logic [MAN_W-1:0] frac;
    logic             inexact;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic adv;
  logic v1_q, v2_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unpack, classify, exponent sum, full mantissa product
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  always_comb begin
    {sign_a, exp_a, man_a} = in_a;
    {sign_b, exp_b, man_b} = in_b;
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (&exp_a) && (man_a == '0);
    inf_b  = (&exp_b) && (man_b == '0);
    nan_a  = (&exp_a) && (man_a != '0);
    nan_b  = (&exp_b) && (man_b != '0);
    snan_a = nan_a && !man_a[MAN_W-1];
    snan_b = nan_b && !man_b[MAN_W-1];

    s1_d         = '0;
    s1_d.sign    = sign_a ^ sign_b;
    s1_d.tag     = in_tag;
    s1_d.e       = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
    s1_d.prod    = PW'({1'b1, man_a}) * PW'({1'b1, man_b});
    s1_d.kind    = K_NORM;
    s1_d.invalid = 1'b0;
    if (nan_a || nan_b) begin
      s1_d.kind    = K_NAN;
      s1_d.invalid = snan_a || snan_b;
    end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
      s1_d.kind    = K_NAN;
      s1_d.invalid = 1'b1;
    end else if (inf_a || inf_b) begin
      s1_d.kind = K_INF;
    end else if (zero_a || zero_b) begin
      s1_d.kind = K_ZERO;
    end
  end

  // S2: normalise to [1,2), round, renormalise on carry-out
  logic [MAN_W-1:0] frac_pre;
  logic             guard, sticky, rnd_up, carry;
  logic [MAN_W-1:0] frac_rnd;
  logic [EW-1:0]    e_norm;

  always_comb begin
    frac_pre = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    e_norm   = s1_q.e;
    if (s1_q.prod[PW-1]) begin
      frac_pre = s1_q.prod[PW-2:MAN_W+1];
      guard    = s1_q.prod[MAN_W];
      sticky   = |s1_q.prod[MAN_W-1:0];
      e_norm   = s1_q.e + EW'(1);
    end else begin
      frac_pre = s1_q.prod[PW-3:MAN_W];
      guard    = s1_q.prod[MAN_W-1];
      sticky   = |s1_q.prod[MAN_W-2:0];
    end

    rnd_up = 1'b0;
`ifdef FP_MULT_PIPE_RNE_EN
    rnd_up = guard && (sticky || frac_pre[0]);
`endif
    // An all-ones fraction rounding up wraps to zero: the value is exactly 2.0
    {carry, frac_rnd} = RW'(frac_pre) + RW'(rnd_up);

    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.kind    = s1_q.kind;
    s2_d.invalid = s1_q.invalid;
    s2_d.tag     = s1_q.tag;
    s2_d.frac    = frac_rnd;
    s2_d.inexact = guard || sticky;
    s2_d.e       = carry ? (e_norm + EW'(1)) : e_norm;
  end

  // S3: range check, pack result and flags {invalid, overflow, underflow, inexact}
  logic [W-1:0] r_d;
  logic [3:0]   flags_d;
  logic         ovf, unf;

  always_comb begin
    r_d     = '0;
    flags_d = '0;
    ovf     = !s2_q.e[EW-1] && (s2_q.e >= EW'(EMAX));
    unf     = s2_q.e[EW-1] || (s2_q.e == '0);
    case (s2_q.kind)
      K_NAN: begin
        r_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = {s2_q.invalid, 3'b000};
      end
      K_INF:  r_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: r_d = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (ovf) begin
          r_d     = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (unf) begin
          r_d     = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          r_d     = {s2_q.sign, s2_q.e[EXP_W-1:0], s2_q.frac};
          flags_d = {3'b000, s2_q.inexact};
        end
      end
    endcase
  end

  // Valid chain and output register; everything holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (v2_q) begin
        out_r     <= r_d;
        out_tag   <= s2_q.tag;
        out_flags <= flags_d;
      end
    end
  end

  // Datapath stages carry no reset; loads are gated by the stage's valid
  always_ff @(posedge clk) begin
    if (adv && in_valid) s1_q <= s1_d;
    if (adv && v1_q)     s2_q <= s2_d;
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vectors, pipeline corner sequences and random traffic
// checked against an arithmetic reference model for fp_mult_pipe (default 8/23 format).
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_r;
  logic [3:0]  in_tag, out_tag, out_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag), .out_flags(out_flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact integer product, then generic normalise/round to a 24-bit significand
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int unsigned     ea, eb;
    longint unsigned ma, mb, p, q, rem;
    int              sh, e;
    logic            sg, an, bn, asn, bsn, ai, bi, az, bz;
`ifdef FP_MULT_PIPE_RNE_EN
    longint unsigned half;
`endif
    ea  = a[30:23];
    eb  = b[30:23];
    ma  = 64'(a[22:0]);
    mb  = 64'(b[22:0]);
    sg  = a[31] ^ b[31];
    an  = (ea == 255) && (ma != 0);
    bn  = (eb == 255) && (mb != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = (ea == 255) && (ma == 0);
    bi  = (eb == 255) && (mb == 0);
    az  = (ea == 0);
    bz  = (eb == 0);
    if (an || bn) return {(asn || bsn), 3'b000, 32'h7FC00000};
    if ((ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, sg, 31'h7F800000};
    if (az || bz) return {4'b0000, sg, 31'h0};
    p  = (ma + 64'h800000) * (mb + 64'h800000);
    sh = 0;
    while ((p >> sh) >= 64'h1000000) sh++;
    q   = p >> sh;
    rem = p - (q << sh);
`ifdef FP_MULT_PIPE_RNE_EN
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    if (q == 64'h1000000) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    e = int'(ea) + int'(eb) - 127 + sh - 23;
    if (e >= 255) return {4'b0101, sg, 31'h7F800000};
    if (e <= 0)   return {4'b0011, sg, 31'h0};
    return {3'b000, (rem != 0), sg, 8'(e), q[22:0]};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: scoreboard every accepted input and output, and check stall stability
  logic        hold_v;
  logic [39:0] hold_val;
  initial begin
    exp_t        e;
    logic [35:0] m;
    hold_v   = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold", {23'd0, out_valid, out_tag, out_flags, out_r}, {23'd0, 1'b1, hold_val});
        hold_v   = out_valid && !out_ready;
        hold_val = {out_tag, out_flags, out_r};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got r=%h tag=%h expected no result", out_r, out_tag);
          end else begin
            e = exp_q.pop_front();
            check("result", {24'd0, out_tag, out_flags, out_r}, {24'd0, e.tag, e.f, e.r});
          end
        end
        if (in_valid && in_ready) begin
          m = ref_mul(in_a, in_b);
          exp_q.push_back('{r: m[31:0], f: m[35:32], tag: in_tag});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and return in the cycle after it transfers
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      step();
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'hFF;
      1: v[30:23] = 8'h00;
      2: v[30:23] = 8'($urandom_range(240, 254));
      3: v[30:23] = 8'($urandom_range(1, 12));
      4: v[22:0]  = 23'h7FFFFF - 23'($urandom_range(0, 3));
      5: v[22:0]  = 23'($urandom_range(0, 3));
      6: v[30:0]  = 31'h7F800000;
      7: v[30:23] = 8'($urandom_range(100, 150));
      default: ;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;
  vec_t vec[19];

  initial begin
    logic        ok;
    int          n, seen;
    logic [3:0]  tg[3];
    logic [31:0] rr[3];

    vec[0]  = '{32'h40000000, 32'h40000000, 32'h40800000, 4'h0};
    vec[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0};
    vec[2]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0};
`ifdef FP_MULT_PIPE_RNE_EN
    vec[3]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'h1};
`else
    vec[3]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00001, 4'h1};
`endif
    vec[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
    vec[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5};
    vec[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
    vec[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
    vec[8]  = '{32'hFF800000, 32'hC0000000, 32'h7F800000, 4'h0};
    vec[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'h0};
    vec[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'h0};
    vec[11] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'h3};
    vec[12] = '{32'h3F000000, 32'h00800000, 32'h00000000, 4'h3};
    vec[13] = '{32'h3F800000, 32'h00800000, 32'h00800000, 4'h0};
    vec[14] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
    vec[15] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0};
    vec[16] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'h1};
`ifdef FP_MULT_PIPE_RNE_EN
    vec[17] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1};
    vec[18] = '{32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 4'h5};
`else
    vec[17] = '{32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 4'h1};
    vec[18] = '{32'h7F7FFFFE, 32'h3F800001, 32'h7F7FFFFF, 4'h1};
`endif

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    step();

    // Single-op latency: 2.0 x 2.0
    send(32'h40000000, 32'h40000000, 4'h5);
    check("lat_c1_valid", out_valid, 0);
    step();
    check("lat_c2_valid", out_valid, 0);
    step();
    check("lat_c3_valid", out_valid, 1);
    check("lat_r", out_r, 32'h40800000);
    check("lat_flags", out_flags, 0);
    check("lat_tag", out_tag, 4'h5);
    step();

    // Back-to-back issue gives back-to-back results
    send(32'h42800000, 32'h42800000, 4'h1);
    send(32'h41000000, 32'h41000000, 4'h2);
    step();
    check("b2b_0_valid", out_valid, 1);
    check("b2b_0", {out_tag, out_r}, {4'h1, 32'h45800000});
    step();
    check("b2b_1_valid", out_valid, 1);
    check("b2b_1", {out_tag, out_r}, {4'h2, 32'h42800000});
    repeat (3) step();

    for (int i = 0; i < 19; i++) begin
      send(vec[i].a, vec[i].b, 4'(i));
      wait_out(ok);
      if (ok) begin
        check($sformatf("vec%0d_r", i), out_r, vec[i].r);
        check($sformatf("vec%0d_flags", i), out_flags, vec[i].f);
      end
      step();
    end
    repeat (3) step();

    // Backpressure: three ops while the consumer stalls
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 4'hA);
    send(32'h40400000, 32'h40000000, 4'hB);
    send(32'h40800000, 32'h40000000, 4'hC);
    check("stall_in_ready", in_ready, 0);
    check("stall_valid", out_valid, 1);
    check("stall_head", {out_tag, out_r}, {4'hA, 32'h40000000});
    repeat (2) begin
      step();
      check("stall_held_r", out_r, 32'h40000000);
      check("stall_held_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12 && n < 3; i++) begin
      if (out_valid) begin
        tg[n] = out_tag;
        rr[n] = out_r;
        n++;
      end
      step();
    end
    check("stall_count", n, 3);
    if (n == 3) begin
      check("stall_out0", {tg[0], rr[0]}, {4'hA, 32'h40000000});
      check("stall_out1", {tg[1], rr[1]}, {4'hB, 32'h40C00000});
      check("stall_out2", {tg[2], rr[2]}, {4'hC, 32'h41000000});
    end
    repeat (3) step();

    // Reset with two results in flight
    send(32'h40000000, 32'h40000000, 4'h7);
    send(32'h3F800000, 32'h40400000, 4'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_r", out_r, 0);
    check("rstmid_tag", out_tag, 0);
    check("rstmid_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("rstmid_discard", seen, 0);

    // Random traffic with random gaps and backpressure
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

endmodule
